// File: rtl/delayslot_exc_commit_pkg.sv
// rtl/delayslot_exc_commit_pkg.sv - shared ExcCode constants, sequencer states and vector default
package delayslot_exc_commit_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } commit_state_t;

endpackage

// File: rtl/delayslot_exc_commit_if.sv
// rtl/delayslot_exc_commit_if.sv - WB commit inputs and flush/redirect outputs of the commit block
//  wb_valid/wb_pc/wb_in_delayslot/wb_exc/wb_exccode/wb_eret/int_pending : committing instruction and events
//  redirect_ready : fetch accepts redirect
//  flush/redirect_valid/redirect_pc/busy : sequencer outputs toward the pipe and fetch
//  master = pipeline/fetch side, slave = commit block
interface delayslot_exc_commit_if #(
    parameter int ADDR_W = 32
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_pc;
    logic              wb_in_delayslot;
    logic              wb_exc;
    logic [4:0]        wb_exccode;
    logic              wb_eret;
    logic              int_pending;
    logic              redirect_ready;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              busy;

    modport master (
        output wb_valid, wb_pc, wb_in_delayslot, wb_exc, wb_exccode, wb_eret,
               int_pending, redirect_ready,
        input  flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  wb_valid, wb_pc, wb_in_delayslot, wb_exc, wb_exccode, wb_eret,
               int_pending, redirect_ready,
        output flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/delayslot_exc_commit_exc_prio_sel.sv
// rtl/delayslot_exc_commit_exc_prio_sel.sv - combinational event priority and EPC/BD/ExcCode select
//  sample          : in  1      events are considered this cycle (RUN and wb_valid)
//  wb_pc           : in  ADDR_W PC of committing instruction
//  wb_in_delayslot : in  1      instruction sits in a delay slot
//  wb_exc/wb_exccode/wb_eret/int_pending : in  event sources
//  take_exc        : out 1      exception or interrupt taken
//  take_eret       : out 1      clean ERET taken
//  exc_code        : out 5      ExcCode to latch
//  epc_next        : out ADDR_W restart PC (branch PC when in a slot)
//  bd_next         : out 1      Cause.BD to latch
module exc_prio_sel
    import delayslot_exc_commit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              sample,
    input  logic [ADDR_W-1:0] wb_pc,
    input  logic              wb_in_delayslot,
    input  logic              wb_exc,
    input  logic [4:0]        wb_exccode,
    input  logic              wb_eret,
    input  logic              int_pending,
    output logic              take_exc,
    output logic              take_eret,
    output logic [4:0]        exc_code,
    output logic [ADDR_W-1:0] epc_next,
    output logic              bd_next
);
    // An ERET in a delay slot is architecturally undefined; it is trapped as RI.
    logic eret_in_slot;

    always_comb begin
        eret_in_slot = wb_eret && wb_in_delayslot;
        take_exc     = sample && (wb_exc || int_pending || eret_in_slot);
        take_eret    = sample && wb_eret && !wb_in_delayslot && !wb_exc && !int_pending;

        if (wb_exc) begin
            exc_code = wb_exccode;
        end else if (int_pending) begin
            exc_code = EXC_INT;
        end else begin
            exc_code = EXC_RI;
        end

        // Restart at the branch so it re-executes; wraps modulo 2^ADDR_W.
        epc_next = wb_in_delayslot ? (wb_pc - ADDR_W'(4)) : wb_pc;
        bd_next  = wb_in_delayslot;
    end
endmodule

// File: rtl/delayslot_exc_commit.sv
// rtl/delayslot_exc_commit.sv - WB commit of exceptions/interrupts/ERET into CP0 state plus flush/redirect sequencer
//  clk, resetn          : clock, asynchronous active-low reset
//  bus (slave)          : WB event inputs, redirect_ready; flush/redirect_valid/redirect_pc/busy outputs
//  epc_wen, epc_wdata   : MTC0 write to EPC
//  epc, cause_bd, cause_exccode, status_exl : architectural CP0 state
module delayslot_exc_commit
    import delayslot_exc_commit_pkg::*;
#(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEFAULT),
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    delayslot_exc_commit_if.slave bus,
    input  logic                 epc_wen,
    input  logic [ADDR_W-1:0]    epc_wdata,
    output logic [ADDR_W-1:0]    epc,
    output logic                 cause_bd,
    output logic [4:0]           cause_exccode,
    output logic                 status_exl
);
    commit_state_t     state;
    logic [3:0]        flush_cnt;

    logic              take_exc;
    logic              take_eret;
    logic [4:0]        exc_code;
    logic [ADDR_W-1:0] epc_next;
    logic              bd_next;

    exc_prio_sel #(.ADDR_W(ADDR_W)) u_prio (
        .sample          (state == ST_RUN && bus.wb_valid),
        .wb_pc           (bus.wb_pc),
        .wb_in_delayslot (bus.wb_in_delayslot),
        .wb_exc          (bus.wb_exc),
        .wb_exccode      (bus.wb_exccode),
        .wb_eret         (bus.wb_eret),
        .int_pending     (bus.int_pending),
        .take_exc        (take_exc),
        .take_eret       (take_eret),
        .exc_code        (exc_code),
        .epc_next        (epc_next),
        .bd_next         (bd_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epc                <= '0;
            cause_bd           <= 1'b0;
            cause_exccode      <= 5'd0;
            status_exl         <= 1'b1;
            state              <= ST_RUN;
            flush_cnt          <= 4'd0;
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= EXC_VECTOR;
            bus.busy           <= 1'b0;
        end else begin
            // CP0 state. take_* are already gated to RUN, so epc_wen alone acts in FLUSH/REDIR.
            if (take_exc) begin
                // With EXL already set this is a nested trap: keep the original restart point.
                if (!status_exl) begin
                    epc      <= epc_next;
                    cause_bd <= bd_next;
                end
                cause_exccode   <= exc_code;
                status_exl      <= 1'b1;
                bus.redirect_pc <= EXC_VECTOR;
            end else begin
                if (take_eret) begin
                    status_exl      <= 1'b0;
                    bus.redirect_pc <= epc;
                end
                if (epc_wen) begin
                    epc <= epc_wdata;
                end
            end

            // Flush/redirect sequencer
            unique case (state)
                ST_RUN: begin
                    if (take_exc || take_eret) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= 4'(FLUSH_CYCLES - 1);
                        bus.flush <= 1'b1;
                        bus.busy  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state              <= ST_REDIR;
                        bus.flush          <= 1'b0;
                        bus.redirect_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                ST_REDIR: begin
                    if (bus.redirect_ready) begin
                        state              <= ST_RUN;
                        bus.redirect_valid <= 1'b0;
                        bus.busy           <= 1'b0;
                    end
                end
                default: begin
                    state              <= ST_RUN;
                    bus.flush          <= 1'b0;
                    bus.redirect_valid <= 1'b0;
                    bus.busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_delayslot_exc_commit.sv
// tb/tb_delayslot_exc_commit.sv - directed self-checking bench for delayslot_exc_commit
module tb_delayslot_exc_commit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk;
    logic        resetn;
    logic        epc_wen;
    logic [31:0] epc_wdata;
    logic [31:0] epc;
    logic        cause_bd;
    logic [4:0]  cause_exccode;
    logic        status_exl;

    int n_vec;
    int n_miss;

    delayslot_exc_commit_if #(.ADDR_W(32)) bus ();

    delayslot_exc_commit #(
        .ADDR_W       (32),
        .EXC_VECTOR   (VEC),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus.slave),
        .epc_wen       (epc_wen),
        .epc_wdata     (epc_wdata),
        .epc           (epc),
        .cause_bd      (cause_bd),
        .cause_exccode (cause_exccode),
        .status_exl    (status_exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.wb_valid        = 1'b0;
        bus.wb_pc           = 32'h0;
        bus.wb_in_delayslot = 1'b0;
        bus.wb_exc          = 1'b0;
        bus.wb_exccode      = 5'd0;
        bus.wb_eret         = 1'b0;
        bus.int_pending     = 1'b0;
        epc_wen             = 1'b0;
        epc_wdata           = 32'h0;
    endtask

    // Called at a negedge; drives one WB cycle and returns at the following negedge.
    task automatic ev(input logic v, input logic [31:0] pc, input logic ds, input logic exc,
                      input logic [4:0] code, input logic eret, input logic intp,
                      input logic wen, input logic [31:0] wdata);
        bus.wb_valid        = v;
        bus.wb_pc           = pc;
        bus.wb_in_delayslot = ds;
        bus.wb_exc          = exc;
        bus.wb_exccode      = code;
        bus.wb_eret         = eret;
        bus.int_pending     = intp;
        epc_wen             = wen;
        epc_wdata           = wdata;
        @(negedge clk);
        clear_inputs();
    endtask

    // Starts at negedge of cycle N+1 after a taken event; returns at a negedge with the sequencer back in RUN.
    task automatic seq(input string tag, input int ready_wait, input logic [31:0] exp_pc);
        chk({tag, ".flush1"}, {31'b0, bus.flush}, 32'd1);
        chk({tag, ".busy1"}, {31'b0, bus.busy}, 32'd1);
        chk({tag, ".rv1"}, {31'b0, bus.redirect_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".flush2"}, {31'b0, bus.flush}, 32'd1);
        @(negedge clk);
        chk({tag, ".flush3"}, {31'b0, bus.flush}, 32'd0);
        chk({tag, ".rv"}, {31'b0, bus.redirect_valid}, 32'd1);
        chk({tag, ".rpc"}, bus.redirect_pc, exp_pc);
        for (int i = 0; i < ready_wait; i++) begin
            @(negedge clk);
            chk({tag, ".rv_hold"}, {31'b0, bus.redirect_valid}, 32'd1);
            chk({tag, ".rpc_hold"}, bus.redirect_pc, exp_pc);
            chk({tag, ".busy_hold"}, {31'b0, bus.busy}, 32'd1);
        end
        bus.redirect_ready = 1'b1;
        @(negedge clk);
        bus.redirect_ready = 1'b0;
        chk({tag, ".rv_done"}, {31'b0, bus.redirect_valid}, 32'd0);
        chk({tag, ".busy_done"}, {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".epc"}, epc, 32'h0);
        chk({tag, ".bd"}, {31'b0, cause_bd}, 32'd0);
        chk({tag, ".code"}, {27'b0, cause_exccode}, 32'd0);
        chk({tag, ".exl"}, {31'b0, status_exl}, 32'd1);
        chk({tag, ".flush"}, {31'b0, bus.flush}, 32'd0);
        chk({tag, ".rv"}, {31'b0, bus.redirect_valid}, 32'd0);
        chk({tag, ".rpc"}, bus.redirect_pc, VEC);
        chk({tag, ".busy"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        clear_inputs();
        bus.redirect_ready = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        resetn = 1'b1;
        @(negedge clk);

        // MTC0 EPC with no event
        ev(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8000_4000);
        chk("mtc0.epc", epc, 32'h8000_4000);
        chk("mtc0.busy", {31'b0, bus.busy}, 32'd0);

        // ERET with same-cycle MTC0: target is the old EPC
        ev(1'b1, 32'h8000_0100, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        chk("eret.exl", {31'b0, status_exl}, 32'd0);
        chk("eret.epc", epc, 32'h1234_5678);
        seq("eret", 0, 32'h8000_4000);

        // Test 1: non-slot exception
        ev(1'b1, 32'h8000_1000, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1.epc", epc, 32'h8000_1000);
        chk("t1.bd", {31'b0, cause_bd}, 32'd0);
        chk("t1.code", {27'b0, cause_exccode}, 32'd4);
        chk("t1.exl", {31'b0, status_exl}, 32'd1);
        seq("t1", 0, VEC);

        // wb_valid=0 carries no event
        ev(1'b0, 32'h8000_9000, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("nv.busy", {31'b0, bus.busy}, 32'd0);
        chk("nv.code", {27'b0, cause_exccode}, 32'd4);
        chk("nv.epc", epc, 32'h8000_1000);

        ev(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        seq("eret2", 0, 32'h8000_1000);

        // Test 2: slot exception, then wraparound at pc 0
        ev(1'b1, 32'h8000_2004, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2.epc", epc, 32'h8000_2000);
        chk("t2.bd", {31'b0, cause_bd}, 32'd1);
        chk("t2.code", {27'b0, cause_exccode}, 32'd8);
        seq("t2", 0, VEC);
        ev(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        seq("eret3", 0, 32'h8000_2000);
        ev(1'b1, 32'h0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2w.epc", epc, 32'hFFFF_FFFC);
        chk("t2w.bd", {31'b0, cause_bd}, 32'd1);
        seq("t2w", 1, VEC);

        // Test 3: nested (EXL=1) slot exception keeps EPC/BD
        ev(1'b1, 32'h8000_3008, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3.epc", epc, 32'hFFFF_FFFC);
        chk("t3.bd", {31'b0, cause_bd}, 32'd1);
        chk("t3.code", {27'b0, cause_exccode}, 32'd12);
        seq("t3", 0, VEC);

        // Interrupt while nested: code 0
        ev(1'b1, 32'h8000_3100, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("int.code", {27'b0, cause_exccode}, 32'd0);
        chk("int.epc", epc, 32'hFFFF_FFFC);
        seq("int", 0, VEC);

        // Test 4b: ERET in a delay slot traps as RI
        ev(1'b1, 32'h8000_3200, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t4b.code", {27'b0, cause_exccode}, 32'd10);
        chk("t4b.exl", {31'b0, status_exl}, 32'd1);
        seq("t4b", 0, VEC);

        ev(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        seq("eret4", 0, 32'hFFFF_FFFC);

        // Test 5: exc+int+eret+epc_wen in one cycle
        ev(1'b1, 32'h8000_5000, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 32'h1111_1111);
        chk("t5.epc", epc, 32'h8000_5000);
        chk("t5.code", {27'b0, cause_exccode}, 32'd5);
        chk("t5.exl", {31'b0, status_exl}, 32'd1);
        // During FLUSH: events ignored, MTC0 honoured
        chk("t5.flush1", {31'b0, bus.flush}, 32'd1);
        ev(1'b1, 32'h8000_6000, 1'b0, 1'b1, 5'd13, 1'b0, 1'b1, 1'b1, 32'hCAFE_0000);
        chk("t5.flush2", {31'b0, bus.flush}, 32'd1);
        chk("t5.ign_code", {27'b0, cause_exccode}, 32'd5);
        chk("t5.mtc0", epc, 32'hCAFE_0000);
        @(negedge clk);
        chk("t5.rv", {31'b0, bus.redirect_valid}, 32'd1);
        chk("t5.rpc", bus.redirect_pc, VEC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5.rv_hold", {31'b0, bus.redirect_valid}, 32'd1);
            chk("t5.rpc_hold", bus.redirect_pc, VEC);
        end
        bus.redirect_ready = 1'b1;
        @(negedge clk);
        bus.redirect_ready = 1'b0;
        chk("t5.rv_done", {31'b0, bus.redirect_valid}, 32'd0);
        chk("t5.busy_done", {31'b0, bus.busy}, 32'd0);

        // Test 6: reset during FLUSH
        ev(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t6a.flush", {31'b0, bus.flush}, 32'd1);
        chk("t6a.rpc", bus.redirect_pc, 32'hCAFE_0000);
        #2 resetn = 1'b0;
        #1 chk_reset("t6a");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset during REDIR
        ev(1'b1, 32'h8000_7000, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk("t6b.rv", {31'b0, bus.redirect_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1 chk_reset("t6b");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("t6b.rv_gone", {31'b0, bus.redirect_valid}, 32'd0);

        // After reset: ERET (EPC=0) then test 1 again
        ev(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        seq("t6e", 0, 32'h0);
        ev(1'b1, 32'h8000_1000, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6.epc", epc, 32'h8000_1000);
        chk("t6.bd", {31'b0, cause_bd}, 32'd0);
        chk("t6.code", {27'b0, cause_exccode}, 32'd4);
        chk("t6.exl", {31'b0, status_exl}, 32'd1);
        seq("t6", 0, VEC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
